// File: rtl/resp_scan_fsm_if.sv
// UART receive-side handshake between the rx buffer and the reply scanner.
// master: scanner (issues unload strobes); slave: UART rx buffer.
interface resp_scan_fsm_if;
    logic       rxempty;
    logic [7:0] rxdata;
    logic       uldrxdata;

    modport master (
        input  rxempty,
        input  rxdata,
        output uldrxdata
    );

    modport slave (
        output rxempty,
        output rxdata,
        input  uldrxdata
    );
endinterface

// File: rtl/resp_scan_fsm.sv
// Scans the UART rx byte stream for an HTTP reply and extracts a t/f verdict from the body.
// Optional feature: define RESP_BYTECOUNT_EN to expose the per-scan unload count on byte_count.
module resp_scan_fsm #(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int QUIET_CYCLES   = 50_000,
    parameter int MAX_BYTES      = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    resp_scan_fsm_if.master rx,
    output logic            done,
    output logic            verdict,
    output logic            valid,
    output logic            timeout
`ifdef RESP_BYTECOUNT_EN
    ,
    output logic [15:0]     byte_count
`endif
);

    localparam int IDLE_MAX = (TIMEOUT_CYCLES > QUIET_CYCLES) ? TIMEOUT_CYCLES : QUIET_CYCLES;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
`ifdef RESP_BYTECOUNT_EN
    localparam int BCNT_W   = 16;
`else
    localparam int BCNT_W   = $clog2(MAX_BYTES + 1);
`endif

    localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] QUIET_LAST   = IDLE_W'(QUIET_CYCLES - 1);
    localparam logic [BCNT_W-1:0] BYTE_LAST    = BCNT_W'(MAX_BYTES - 1);

    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_T  = 8'h74;
    localparam logic [7:0] CHR_F  = 8'h66;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BODY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              strobe_q;
    logic              strobe;
    logic              scanning;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    logic [BCNT_W-1:0] byte_cnt, byte_nxt;
    logic [1:0]        idx, idx_nxt;
    logic              done_nxt, verdict_nxt, valid_nxt, timeout_nxt;

    function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Terminator is CR LF CR LF: even positions expect CR, odd positions expect LF.
    function automatic logic [7:0] hdr_expect(input logic [1:0] pos);
        return pos[0] ? CHR_LF : CHR_CR;
    endfunction

    function automatic logic is_skip(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h09) || (b == CHR_CR) || (b == CHR_LF) || (b == 8'h22);
    endfunction

    // A strobe is never issued on the cycle after a strobe so rxempty has time to update.
    assign scanning     = (state == S_HDR) || (state == S_BODY) || (state == S_DRAIN);
    assign strobe       = scanning && !rx.rxempty && !strobe_q && !reset;
    assign rx.uldrxdata = strobe;

`ifdef RESP_BYTECOUNT_EN
    assign byte_count = byte_cnt;
`endif

    always_comb begin
        state_nxt   = state;
        idle_nxt    = idle_cnt;
        byte_nxt    = byte_cnt;
        idx_nxt     = idx;
        done_nxt    = done;
        verdict_nxt = verdict;
        valid_nxt   = valid;
        timeout_nxt = timeout;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt   = S_HDR;
                    idle_nxt    = '0;
                    byte_nxt    = '0;
                    idx_nxt     = '0;
                    done_nxt    = 1'b0;
                    verdict_nxt = 1'b0;
                    valid_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end

            S_HDR, S_BODY: begin
                if (strobe) begin
                    idle_nxt = '0;
                    byte_nxt = sat_inc(byte_cnt);
                    if (byte_cnt == BYTE_LAST) begin
                        // Byte limit wins over whatever this byte would have meant.
                        state_nxt   = S_DONE;
                        done_nxt    = 1'b1;
                        valid_nxt   = 1'b0;
                        timeout_nxt = 1'b0;
                    end else if (state == S_HDR) begin
                        if (rx.rxdata == hdr_expect(idx)) begin
                            if (idx == 2'd3) begin
                                state_nxt = S_BODY;
                                idx_nxt   = '0;
                            end else begin
                                idx_nxt = idx + 2'd1;
                            end
                        end else begin
                            idx_nxt = (rx.rxdata == CHR_CR) ? 2'd1 : 2'd0;
                        end
                    end else if (!is_skip(rx.rxdata)) begin
                        state_nxt   = S_DRAIN;
                        verdict_nxt = (rx.rxdata == CHR_T);
                        valid_nxt   = (rx.rxdata == CHR_T) || (rx.rxdata == CHR_F);
                    end
                end else if (idle_cnt == TIMEOUT_LAST) begin
                    state_nxt   = S_DONE;
                    done_nxt    = 1'b1;
                    valid_nxt   = 1'b0;
                    timeout_nxt = 1'b1;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end

            S_DRAIN: begin
                if (strobe) begin
                    idle_nxt = '0;
                    byte_nxt = sat_inc(byte_cnt);
                end else if (rx.rxempty && (idle_cnt == QUIET_LAST)) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else if (idle_cnt != QUIET_LAST) begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            strobe_q <= 1'b0;
            idle_cnt <= '0;
            byte_cnt <= '0;
            idx      <= '0;
            done     <= 1'b0;
            verdict  <= 1'b0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            strobe_q <= strobe;
            idle_cnt <= idle_nxt;
            byte_cnt <= byte_nxt;
            idx      <= idx_nxt;
            done     <= done_nxt;
            verdict  <= verdict_nxt;
            valid    <= valid_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_resp_scan_fsm.sv
// Bench for resp_scan_fsm: a queue-based UART rx buffer feeds directed and random replies,
// and outcomes are compared with a string-level reply parser.
module tb_resp_scan_fsm;

    localparam int TO = 100;
    localparam int QT = 40;
    localparam int MB = 24;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done, verdict, valid, timeout;
`ifdef RESP_BYTECOUNT_EN
    logic [15:0] byte_count;
`endif

    resp_scan_fsm_if rx();

    resp_scan_fsm #(
        .TIMEOUT_CYCLES(TO),
        .QUIET_CYCLES  (QT),
        .MAX_BYTES     (MB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rx     (rx),
        .done   (done),
        .verdict(verdict),
        .valid  (valid),
        .timeout(timeout)
`ifdef RESP_BYTECOUNT_EN
        ,
        .byte_count(byte_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pops  = 0;
    int b2b   = 0;
    logic prev_strobe = 1'b0;
    logic strobe_seen = 1'b0;
    logic [7:0] fifo[$];
    logic [7:0] stim[$];
    logic [7:0] hdr_pool [6] = '{8'h41, 8'h62, 8'h0D, 8'h0A, 8'h20, 8'h74};
    logic [7:0] skip_pool[5] = '{8'h20, 8'h09, 8'h0D, 8'h0A, 8'h22};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_rx();
        rx.rxempty = (fifo.size() == 0);
        rx.rxdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: sample the strobe mid-cycle, pop the buffer after the edge that consumed it.
    task automatic tick();
        @(negedge clk);
        strobe_seen = rx.uldrxdata;
        if (strobe_seen && prev_strobe) b2b++;
        prev_strobe = strobe_seen;
        @(posedge clk);
        #1;
        if (strobe_seen) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pops++;
        end
        drive_rx();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        if (done !== 1'b1) chk({tag, "_done_in_time"}, 32'd0, 32'd1);
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic add_crlf();
        stim.push_back(8'h0D);
        stim.push_back(8'h0A);
    endtask

    // Reply parser: first CRLFCRLF substring, then first non-whitespace/quote byte.
    function automatic void model(output int e_valid, output int e_verdict,
                                  output int e_timeout, output int e_pops);
        int n = stim.size();
        int hdr = -1;
        int dec = -1;
        int used;
        for (int i = 3; i < n; i++)
            if (hdr < 0 && stim[i-3] == 8'h0D && stim[i-2] == 8'h0A &&
                stim[i-1] == 8'h0D && stim[i] == 8'h0A) hdr = i;
        if (hdr >= 0)
            for (int j = hdr + 1; j < n; j++)
                if (dec < 0 && !(stim[j] inside {8'h20, 8'h09, 8'h0D, 8'h0A, 8'h22})) dec = j;
        used      = (dec >= 0) ? dec + 1 : n;
        e_valid   = 0;
        e_verdict = 0;
        e_timeout = 0;
        if (used >= MB) begin
            e_pops = MB;
        end else if (dec < 0) begin
            e_timeout = 1;
            e_pops    = n;
        end else begin
            e_pops    = n;
            e_verdict = (stim[dec] == 8'h74) ? 1 : 0;
            e_valid   = (stim[dec] == 8'h74 || stim[dec] == 8'h66) ? 1 : 0;
        end
    endfunction

    task automatic run_stream(input string tag, input int max_gap);
        int e_valid, e_verdict, e_timeout, e_pops, waited;
        pops = 0;
        pulse_start();
        foreach (stim[k]) begin
            fifo.push_back(stim[k]);
            drive_rx();
            repeat ($urandom_range(max_gap)) tick();
        end
        wait_done(tag, 600, waited);
        repeat (8) tick();
        model(e_valid, e_verdict, e_timeout, e_pops);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_valid"}, valid, e_valid);
        if (e_valid != 0) chk({tag, "_verdict"}, verdict, e_verdict);
        chk({tag, "_timeout"}, timeout, e_timeout);
        chk({tag, "_unloads"}, pops, e_pops);
        chk({tag, "_left_in_uart"}, fifo.size(), stim.size() - e_pops);
`ifdef RESP_BYTECOUNT_EN
        chk({tag, "_byte_count"}, byte_count, e_pops);
`endif
        fifo.delete();
        drive_rx();
    endtask

    initial begin
        int k;
        int p;
        logic [5:0] pat;
        reset = 1'b1;
        start = 1'b0;
        drive_rx();
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_verdict", verdict, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_strobe", rx.uldrxdata, 0);
`ifdef RESP_BYTECOUNT_EN
        chk("rst_byte_count", byte_count, 0);
`endif

        stim.delete();
        add_str("HTTP/1.1 200"); add_crlf(); add_crlf(); add_str("true");
        run_stream("http_true", 3);
        chk("http_true_lit_valid", valid, 1);
        chk("http_true_lit_verdict", verdict, 1);
        chk("http_true_lit_unloads", pops, 20);

        stim.delete();
        add_str("X"); add_crlf(); add_crlf(); add_str("  \"false\"");
        run_stream("quoted_false", 3);
        chk("quoted_false_lit_valid", valid, 1);
        chk("quoted_false_lit_verdict", verdict, 0);

        stim.delete();
        add_str("AB"); stim.push_back(8'h0D); add_crlf(); add_crlf(); add_str("t");
        run_stream("resync", 2);
        chk("resync_lit_valid", valid, 1);
        chk("resync_lit_verdict", verdict, 1);

        stim.delete();
        repeat (30) stim.push_back(8'h61);
        run_stream("max_bytes", 1);
        chk("max_bytes_lit_unloads", pops, MB);
        chk("max_bytes_lit_valid", valid, 0);

        // Timeout latency with no bytes at all.
        pops = 0;
        pulse_start();
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        chk("timeout_latency", k, TO);
        chk("timeout_flag", timeout, 1);
        chk("timeout_valid", valid, 0);

        // Continuous backlog: strobes alternate.
        pops = 0;
        repeat (8) fifo.push_back(8'h7A);
        drive_rx();
        pulse_start();
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pat = {pat[4:0], strobe_seen};
        end
        chk("strobe_toggle", pat, 6'b101010);
        wait_done("toggle", 600, k);
        chk("toggle_unloads", pops, 8);
        chk("toggle_timeout", timeout, 1);
        fifo.delete();
        drive_rx();

        // Reset in the middle of the header.
        pops = 0;
        pulse_start();
        fifo.push_back(8'h61); fifo.push_back(8'h62); fifo.push_back(8'h63);
        drive_rx();
        repeat (3) tick();
        p = pops;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_done", done, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_strobe", rx.uldrxdata, 0);
        repeat (6) tick();
        chk("midrst_no_unloads", pops, p);
        fifo.delete();
        drive_rx();

        // start while in BODY must be ignored.
        pops = 0;
        pulse_start();
        fifo.push_back(8'h0D); fifo.push_back(8'h0A); fifo.push_back(8'h0D); fifo.push_back(8'h0A);
        drive_rx();
        repeat (10) tick();
        chk("body_hdr_unloads", pops, 4);
        pulse_start();
        fifo.push_back(8'h20); fifo.push_back(8'h74);
        drive_rx();
        wait_done("body_start", 600, k);
        chk("body_start_valid", valid, 1);
        chk("body_start_verdict", verdict, 1);
        chk("body_start_timeout", timeout, 0);
        chk("body_start_unloads", pops, 6);
        fifo.delete();
        drive_rx();

        for (int it = 0; it < 25; it++) begin
            stim.delete();
            repeat ($urandom_range(10)) stim.push_back(hdr_pool[$urandom_range(5)]);
            if ($urandom_range(9) < 8) begin
                add_crlf();
                add_crlf();
            end
            repeat ($urandom_range(4)) stim.push_back(skip_pool[$urandom_range(4)]);
            case ($urandom_range(3))
                0: stim.push_back(8'h74);
                1: stim.push_back(8'h66);
                2: stim.push_back(8'h78);
                default: ;
            endcase
            repeat ($urandom_range(5)) stim.push_back(8'($urandom_range(255)));
            run_stream("random", 4);
        end

        chk("no_back_to_back_strobes", b2b, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
